// File: rtl/axi_data_bridge_pkg.sv
// Shared definitions for the data-side AXI bridge: FSM states and fixed AXI field encodings.
package axi_data_bridge_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_FW = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [AXI_SIZE_FW-1:0] AXI_SIZE_W     = 3'b010;
    localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_AR,
        S_RD_R,
        S_WR_REQ,
        S_WR_B,
        S_RESP
    } bridge_state_t;

endpackage

// File: rtl/axi_data_bridge.sv
// Serialises core data-port loads/stores into single-beat AXI transactions, one outstanding at a time.
module axi_data_bridge
    import axi_data_bridge_pkg::*;
#(
    parameter int              ID_W   = 4,
    parameter int              ADDR_W = 32,
    parameter int              DATA_W = 32,
    parameter logic [ID_W-1:0] RD_ID  = ID_W'(1),
    parameter logic [ID_W-1:0] WR_ID  = ID_W'(1),
    parameter logic [5:0]      BUSERR = 6'h0a
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    data_req,
    input  logic                    data_wr,
    input  logic [DATA_W/8-1:0]     data_wstrb,
    input  logic [ADDR_W-1:0]       data_addr,
    input  logic [DATA_W-1:0]       data_wdata,
    input  logic                    data_cancel,
    output logic                    data_addr_ok,
    output logic                    data_data_ok,
    output logic [DATA_W-1:0]       data_rdata,
    output logic [5:0]              data_exccode,
    output logic [ID_W-1:0]         arid,
    output logic [ADDR_W-1:0]       araddr,
    output logic [AXI_LEN_W-1:0]    arlen,
    output logic [AXI_SIZE_FW-1:0]  arsize,
    output logic [AXI_BURST_W-1:0]  arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_W-1:0]         rid,
    input  logic [DATA_W-1:0]       rdata,
    input  logic [AXI_RESP_W-1:0]   rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ID_W-1:0]         awid,
    output logic [ADDR_W-1:0]       awaddr,
    output logic [AXI_LEN_W-1:0]    awlen,
    output logic [AXI_SIZE_FW-1:0]  awsize,
    output logic [AXI_BURST_W-1:0]  awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ID_W-1:0]         wid,
    output logic [DATA_W-1:0]       wdata,
    output logic [DATA_W/8-1:0]     wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_W-1:0]         bid,
    input  logic [AXI_RESP_W-1:0]   bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    bridge_state_t state, next_state;

    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [5:0]          exccode_q;
    logic                cancel_q;
    logic                aw_done;
    logic                w_done;

    // Responses are attributed to the single outstanding request, so ids and the byte offset go unused.
    logic unused_inputs;
    assign unused_inputs = ^{rid, bid, data_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        case (state)
            S_IDLE: begin
                data_addr_ok = data_req;
                if (data_req) begin
                    next_state = data_wr ? S_WR_REQ : S_RD_AR;
                end
            end
            S_RD_AR: begin
                arvalid = 1'b1;
                if (arready) next_state = S_RD_R;
            end
            S_RD_R: begin
                rready = 1'b1;
                if (rvalid && rlast) next_state = S_RESP;
            end
            S_WR_REQ: begin
                // AW and W complete independently; a channel already done must not re-present.
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) next_state = S_WR_B;
            end
            S_WR_B: begin
                bready = 1'b1;
                if (bvalid) next_state = S_RESP;
            end
            S_RESP: begin
                data_data_ok = !cancel_q;
                next_state   = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            exccode_q <= '0;
            cancel_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            if (data_addr_ok) begin
                addr_q    <= {data_addr[ADDR_W-1:2], 2'b00};
                wdata_q   <= data_wdata;
                wstrb_q   <= data_wstrb;
                rdata_q   <= '0;
                exccode_q <= '0;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
            end
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
            if (rready && rvalid && rlast) begin
                rdata_q   <= (rresp == AXI_RESP_OKAY) ? rdata : '0;
                exccode_q <= (rresp == AXI_RESP_OKAY) ? 6'h00 : BUSERR;
            end
            if (bready && bvalid) begin
                exccode_q <= (bresp == AXI_RESP_OKAY) ? 6'h00 : BUSERR;
            end
            // The cancel flag lives exactly as long as the transaction it squashes.
            if (state == S_RESP) begin
                cancel_q <= 1'b0;
            end else if (state != S_IDLE && data_cancel) begin
                cancel_q <= 1'b1;
            end
        end
    end

    assign data_rdata   = rdata_q;
    assign data_exccode = exccode_q;

    assign arid    = RD_ID;
    assign araddr  = addr_q;
    assign arlen   = '0;
    assign arsize  = AXI_SIZE_W;
    assign arburst = AXI_BURST_INCR;

    assign awid    = WR_ID;
    assign awaddr  = addr_q;
    assign awlen   = '0;
    assign awsize  = AXI_SIZE_W;
    assign awburst = AXI_BURST_INCR;

    assign wid     = WR_ID;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;

endmodule
